// File: rtl/mem_stage_lsu_pkg.sv
// Shared pipeline definitions for the memory stage: access-size codes,
// LSU FSM states and writeback mux select encodings.
package mem_stage_lsu_pkg;

    localparam int unsigned XLEN = 64;

    // func3 access size/sign codes
    localparam logic [2:0] MEM_B  = 3'd0;
    localparam logic [2:0] MEM_H  = 3'd1;
    localparam logic [2:0] MEM_W  = 3'd2;
    localparam logic [2:0] MEM_D  = 3'd3;
    localparam logic [2:0] MEM_BU = 3'd4;
    localparam logic [2:0] MEM_HU = 3'd5;
    localparam logic [2:0] MEM_WU = 3'd6;

    // Writeback mux select encodings
    localparam logic [2:0] RESULT_SRC_ALU = 3'd0;
    localparam logic [2:0] RESULT_SRC_MEM = 3'd1;
    localparam logic [2:0] RESULT_SRC_PC4 = 3'd2;
    localparam logic [2:0] RESULT_SRC_IMM = 3'd3;
    localparam logic [2:0] RESULT_SRC_PCT = 3'd4;

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } t_lsu_state;

    // Low address bits that must be zero for an access of 2**size_log2 bytes.
    function automatic logic [2:0] offset_mask(input logic [1:0] size_log2);
        logic [2:0] mask;
        case (size_log2)
            2'd0:    mask = 3'b000;
            2'd1:    mask = 3'b001;
            2'd2:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

    // Unshifted byte-enable pattern for an access of 2**size_log2 bytes.
    function automatic logic [7:0] size_byte_mask(input logic [1:0] size_log2);
        logic [7:0] mask;
        case (size_log2)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane steering for 64-bit data memory accesses: byte enables,
// store data shifting and load data alignment/extension.
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]      i_func3,
    input  logic [2:0]      i_offset,
    input  logic [XLEN-1:0] i_store_data,
    input  logic [XLEN-1:0] i_rdata,
    output logic [7:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_load_data
);

    logic [XLEN-1:0] shifted;

    assign o_be    = size_byte_mask(i_func3[1:0]) << i_offset;
    assign o_wdata = i_store_data << {i_offset, 3'b000};

    always_comb begin
        shifted     = i_rdata >> {i_offset, 3'b000};
        o_load_data = shifted;
        case (i_func3)
            MEM_B:   o_load_data = {{56{shifted[7]}}, shifted[7:0]};
            MEM_H:   o_load_data = {{48{shifted[15]}}, shifted[15:0]};
            MEM_W:   o_load_data = {{32{shifted[31]}}, shifted[31:0]};
            MEM_BU:  o_load_data = {56'd0, shifted[7:0]};
            MEM_HU:  o_load_data = {48'd0, shifted[15:0]};
            MEM_WU:  o_load_data = {32'd0, shifted[31:0]};
            // MEM_D and the unused code 7 both take the full doubleword
            default: o_load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage: drives the data memory req/ack handshake, stalls upstream while
// an access is outstanding, and loads the memory/writeback pipeline register.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic [2:0]              i_result_src,
    input  logic                    i_mem_re,
    input  logic                    i_mem_we,
    input  logic                    i_reg_we,
    input  logic [2:0]              i_func3,
    input  logic [ADDR_WIDTH-1:0]   i_pc_plus4,
    input  logic [ADDR_WIDTH-1:0]   i_pc_target,
    input  logic [DATA_WIDTH-1:0]   i_imm_ext,
    input  logic [DATA_WIDTH-1:0]   i_alu_result,
    input  logic [DATA_WIDTH-1:0]   i_write_data,
    input  logic [REG_ADDR_W-1:0]   i_rd_addr,
    output logic                    o_dmem_req,
    output logic                    o_dmem_we,
    output logic [ADDR_WIDTH-1:0]   o_dmem_addr,
    output logic [DATA_WIDTH-1:0]   o_dmem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_dmem_be,
    input  logic                    i_dmem_ack,
    input  logic [DATA_WIDTH-1:0]   i_dmem_rdata,
    output logic                    o_stall,
    output logic                    o_misaligned,
    output logic [2:0]              o_result_src,
    output logic                    o_reg_we,
    output logic [REG_ADDR_W-1:0]   o_rd_addr,
    output logic [ADDR_WIDTH-1:0]   o_pc_plus4,
    output logic [ADDR_WIDTH-1:0]   o_pc_target,
    output logic [DATA_WIDTH-1:0]   o_imm_ext,
    output logic [DATA_WIDTH-1:0]   o_alu_result,
    output logic [DATA_WIDTH-1:0]   o_read_data
);

    t_lsu_state state_q, state_d;

    logic                  mem_op;
    logic                  is_load;
    logic                  misaligned;
    logic                  mem_fault;
    logic [DATA_WIDTH-1:0] load_data;

    logic [2:0]            result_src_q;
    logic                  reg_we_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] pc_plus4_q;
    logic [ADDR_WIDTH-1:0] pc_target_q;
    logic [DATA_WIDTH-1:0] imm_ext_q;
    logic [DATA_WIDTH-1:0] alu_result_q;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  misaligned_q;

    assign mem_op     = i_mem_re | i_mem_we;
    // a combined re/we request is treated as a store
    assign is_load    = i_mem_re & ~i_mem_we;
    assign misaligned = (i_alu_result[2:0] & offset_mask(i_func3[1:0])) != 3'b000;
    assign mem_fault  = mem_op & misaligned;

    mem_stage_lsu_align u_align (
        .i_func3      (i_func3),
        .i_offset     (i_alu_result[2:0]),
        .i_store_data (i_write_data),
        .i_rdata      (i_dmem_rdata),
        .o_be         (o_dmem_be),
        .o_wdata      (o_dmem_wdata),
        .o_load_data  (load_data)
    );

    // Address, be and wdata come straight from the stalled execute register,
    // so they stay stable for the whole WAIT period.
    assign o_dmem_addr = {i_alu_result[ADDR_WIDTH-1:3], 3'b000};
    assign o_dmem_we   = o_dmem_req & i_mem_we;

    always_comb begin
        state_d    = state_q;
        o_dmem_req = 1'b0;
        o_stall    = 1'b0;
        if (!i_arst) begin
            case (state_q)
                StIdle: begin
                    if (mem_op && !misaligned) begin
                        o_dmem_req = 1'b1;
                        if (!i_dmem_ack) begin
                            o_stall = 1'b1;
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    o_dmem_req = 1'b1;
                    o_stall    = ~i_dmem_ack;
                    if (i_dmem_ack) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A stalled cycle inserts a bubble so an outstanding load writes back once.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            result_src_q <= '0;
            reg_we_q     <= 1'b0;
            rd_addr_q    <= '0;
            pc_plus4_q   <= '0;
            pc_target_q  <= '0;
            imm_ext_q    <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            misaligned_q <= 1'b0;
        end else if (o_stall) begin
            reg_we_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            result_src_q <= i_result_src;
            reg_we_q     <= i_reg_we & ~mem_fault;
            rd_addr_q    <= i_rd_addr;
            pc_plus4_q   <= i_pc_plus4;
            pc_target_q  <= i_pc_target;
            imm_ext_q    <= i_imm_ext;
            alu_result_q <= i_alu_result;
            read_data_q  <= (is_load && !misaligned) ? load_data : '0;
            misaligned_q <= mem_fault;
        end
    end

    assign o_result_src = result_src_q;
    assign o_reg_we     = reg_we_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_pc_plus4   = pc_plus4_q;
    assign o_pc_target  = pc_target_q;
    assign o_imm_ext    = imm_ext_q;
    assign o_alu_result = alu_result_q;
    assign o_read_data  = read_data_q;
    assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
module tb_mem_stage_lsu;

    logic        i_clk;
    logic        i_arst;
    logic [2:0]  i_result_src;
    logic        i_mem_re;
    logic        i_mem_we;
    logic        i_reg_we;
    logic [2:0]  i_func3;
    logic [63:0] i_pc_plus4;
    logic [63:0] i_pc_target;
    logic [63:0] i_imm_ext;
    logic [63:0] i_alu_result;
    logic [63:0] i_write_data;
    logic [4:0]  i_rd_addr;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [63:0] o_dmem_addr;
    logic [63:0] o_dmem_wdata;
    logic [7:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [63:0] i_dmem_rdata;
    logic        o_stall;
    logic        o_misaligned;
    logic [2:0]  o_result_src;
    logic        o_reg_we;
    logic [4:0]  o_rd_addr;
    logic [63:0] o_pc_plus4;
    logic [63:0] o_pc_target;
    logic [63:0] o_imm_ext;
    logic [63:0] o_alu_result;
    logic [63:0] o_read_data;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_lsu dut (
        .i_clk        (i_clk),
        .i_arst       (i_arst),
        .i_result_src (i_result_src),
        .i_mem_re     (i_mem_re),
        .i_mem_we     (i_mem_we),
        .i_reg_we     (i_reg_we),
        .i_func3      (i_func3),
        .i_pc_plus4   (i_pc_plus4),
        .i_pc_target  (i_pc_target),
        .i_imm_ext    (i_imm_ext),
        .i_alu_result (i_alu_result),
        .i_write_data (i_write_data),
        .i_rd_addr    (i_rd_addr),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .o_dmem_be    (o_dmem_be),
        .i_dmem_ack   (i_dmem_ack),
        .i_dmem_rdata (i_dmem_rdata),
        .o_stall      (o_stall),
        .o_misaligned (o_misaligned),
        .o_result_src (o_result_src),
        .o_reg_we     (o_reg_we),
        .o_rd_addr    (o_rd_addr),
        .o_pc_plus4   (o_pc_plus4),
        .o_pc_target  (o_pc_target),
        .o_imm_ext    (o_imm_ext),
        .o_alu_result (o_alu_result),
        .o_read_data  (o_read_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_result_src = 3'd0;
        i_mem_re     = 1'b0;
        i_mem_we     = 1'b0;
        i_reg_we     = 1'b0;
        i_func3      = 3'd0;
        i_pc_plus4   = 64'd0;
        i_pc_target  = 64'd0;
        i_imm_ext    = 64'd0;
        i_alu_result = 64'd0;
        i_write_data = 64'd0;
        i_rd_addr    = 5'd0;
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 64'd0;
    endtask

    task automatic load(input logic [2:0] f3, input logic [63:0] addr, input logic ack,
                        input logic [63:0] rdata);
        idle_inputs();
        i_mem_re     = 1'b1;
        i_reg_we     = 1'b1;
        i_result_src = 3'd1;
        i_rd_addr    = 5'd5;
        i_func3      = f3;
        i_alu_result = addr;
        i_dmem_ack   = ack;
        i_dmem_rdata = rdata;
    endtask

    initial begin
        idle_inputs();
        i_arst = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_req", o_dmem_req, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_reg_we", o_reg_we, 0);
        chk("rst_read_data", o_read_data, 0);
        chk("rst_misaligned", o_misaligned, 0);
        chk("rst_alu_result", o_alu_result, 0);

        // Zero-wait LD
        tick();
        i_arst = 1'b0;
        load(3'd3, 64'h1000, 1'b1, 64'h1122334455667788);
        #1;
        chk("ld_req", o_dmem_req, 1);
        chk("ld_stall", o_stall, 0);
        chk("ld_addr", o_dmem_addr, 64'h1000);
        chk("ld_be", o_dmem_be, 8'hFF);
        chk("ld_we", o_dmem_we, 0);
        tick();
        idle_inputs();
        #1;
        chk("ld_read_data", o_read_data, 64'h1122334455667788);
        chk("ld_reg_we", o_reg_we, 1);
        chk("ld_rd_addr", o_rd_addr, 5);
        chk("ld_result_src", o_result_src, 1);
        tick();
        #1;
        chk("ld_reg_we_after", o_reg_we, 0);

        // LB sign-extended, ack after two stalled cycles
        tick();
        load(3'd0, 64'h1003, 1'b0, 64'h0000_0000_8000_0000);
        #1;
        chk("lb_stall0", o_stall, 1);
        chk("lb_req0", o_dmem_req, 1);
        chk("lb_be", o_dmem_be, 8'h08);
        tick();
        #1;
        chk("lb_stall1", o_stall, 1);
        chk("lb_req1", o_dmem_req, 1);
        chk("lb_reg_we_bubble1", o_reg_we, 0);
        tick();
        i_dmem_ack = 1'b1;
        #1;
        chk("lb_stall2", o_stall, 0);
        chk("lb_reg_we_bubble2", o_reg_we, 0);
        tick();
        idle_inputs();
        #1;
        chk("lb_read_data", o_read_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_reg_we", o_reg_we, 1);
        tick();
        #1;
        chk("lb_reg_we_once", o_reg_we, 0);

        // LBU with the same stimulus
        load(3'd4, 64'h1003, 1'b0, 64'h0000_0000_8000_0000);
        tick();
        tick();
        i_dmem_ack = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("lbu_read_data", o_read_data, 64'h80);
        chk("lbu_reg_we", o_reg_we, 1);

        // SH to upper halfword lane
        tick();
        idle_inputs();
        i_mem_we     = 1'b1;
        i_func3      = 3'd1;
        i_alu_result = 64'h2006;
        i_write_data = 64'hBEEF;
        i_dmem_ack   = 1'b1;
        #1;
        chk("sh_req", o_dmem_req, 1);
        chk("sh_we", o_dmem_we, 1);
        chk("sh_be", o_dmem_be, 8'hC0);
        chk("sh_wdata", o_dmem_wdata, 64'hBEEF_0000_0000_0000);
        chk("sh_addr", o_dmem_addr, 64'h2000);
        chk("sh_stall", o_stall, 0);
        tick();
        idle_inputs();
        #1;
        chk("sh_reg_we", o_reg_we, 0);
        chk("sh_read_data", o_read_data, 0);

        // Misaligned LW
        tick();
        load(3'd2, 64'h3002, 1'b0, 64'd0);
        #1;
        chk("mis_req", o_dmem_req, 0);
        chk("mis_stall", o_stall, 0);
        tick();
        idle_inputs();
        #1;
        chk("mis_pulse", o_misaligned, 1);
        chk("mis_reg_we", o_reg_we, 0);
        tick();
        #1;
        chk("mis_pulse_end", o_misaligned, 0);

        // ALU op, then a load that gets reset while waiting
        tick();
        idle_inputs();
        i_reg_we     = 1'b1;
        i_alu_result = 64'h42;
        i_pc_plus4   = 64'h104;
        i_rd_addr    = 5'd9;
        #1;
        chk("alu_req", o_dmem_req, 0);
        chk("alu_stall", o_stall, 0);
        tick();
        load(3'd3, 64'h4000, 1'b0, 64'd0);
        #1;
        chk("alu_result", o_alu_result, 64'h42);
        chk("alu_reg_we", o_reg_we, 1);
        chk("alu_rd_addr", o_rd_addr, 9);
        chk("alu_pc_plus4", o_pc_plus4, 64'h104);
        chk("wait_stall0", o_stall, 1);
        tick();
        #1;
        chk("wait_stall1", o_stall, 1);
        chk("wait_hold_alu", o_alu_result, 64'h42);
        tick();
        i_arst = 1'b1;
        #1;
        chk("rstw_req", o_dmem_req, 0);
        chk("rstw_stall", o_stall, 0);
        tick();
        i_arst = 1'b0;
        idle_inputs();
        i_dmem_ack = 1'b1;
        #1;
        chk("rstw_alu_result", o_alu_result, 0);
        chk("rstw_pc_plus4", o_pc_plus4, 0);
        chk("rstw_rd_addr", o_rd_addr, 0);
        chk("late_ack_req", o_dmem_req, 0);
        chk("late_ack_stall", o_stall, 0);
        tick();
        i_dmem_ack = 1'b0;
        #1;
        chk("late_ack_reg_we", o_reg_we, 0);
        chk("late_ack_read_data", o_read_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
